// File: rtl/spi_flash_rom_pkg.sv
// Shared types and constants for the SPI NOR flash read-only backend.
package spi_flash_rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2,
        ST_DESEL = 2'd3
    } state_t;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam int         SPI_FRAME_SCK = 96;
    localparam int         SPI_TX_BITS   = 32;

    // Bit position in the 64-bit line for a received bit. Bytes land
    // little-endian, bits arrive MSB-first within each byte.
    function automatic logic [5:0] rx_bit_pos(input logic [5:0] frame_bit);
        logic [5:0] j;
        j = frame_bit - 6'(SPI_TX_BITS);
        return {j[5:3], ~j[2:0]};
    endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// System-bus width definitions shared by the memory backends behind axi_slv.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

endpackage

// File: rtl/spi_flash_rom_sck_gen.sv
// SCK divider: toggles SCK every sck_div cycles while enabled and flags
// the clock edge on which SCK rises or falls.
module spi_sck_gen #(
    parameter int sck_div = 1
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_en,
    input  logic i_sck_en,
    output logic o_sck,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [7:0] DIV_LAST = 8'(sck_div - 1);

    logic [7:0] div_cnt_reg;
    logic       sck_reg;

    // tick also paces the deselect gap, where SCK itself stays parked low
    assign o_tick = i_en && (div_cnt_reg == DIV_LAST);
    assign o_rise = o_tick && i_sck_en && !sck_reg;
    assign o_fall = o_tick && i_sck_en && sck_reg;
    assign o_sck  = sck_reg;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
        end else if (!i_en) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
        end else if (o_tick) begin
            div_cnt_reg <= '0;
            if (i_sck_en) begin
                sck_reg <= ~sck_reg;
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/spi_flash_rom.sv
// Read-only sysbus backend fetching 64-bit lines from SPI NOR flash (0x03
// read, mode 0) with a one-line buffer for repeated reads of the same word.
module spi_flash_rom
    import types_amba_pkg::*;
    import spi_flash_rom_pkg::*;
#(
    parameter int abits   = 24,
    parameter int sck_div = 1
) (
    input  logic                             i_clk,
    input  logic                             i_nrst,
    input  logic                             i_req_valid,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic [7:0]                       i_req_size,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
    input  logic                             i_req_last,
    output logic                             o_req_ready,
    output logic                             o_resp_valid,
    output logic [63:0]                      o_resp_rdata,
    output logic                             o_resp_err,
    output logic                             o_spi_sck,
    output logic                             o_spi_cs_n,
    output logic                             o_spi_mosi,
    input  logic                             i_spi_miso
);

    localparam int TAG_W = abits - 3;

    state_t             state_reg;
    logic               ready_reg;
    logic               resp_valid_reg;
    logic [63:0]        rdata_reg;
    logic               err_reg;
    logic               cs_n_reg;
    logic               mosi_reg;
    logic [31:0]        tx_reg;
    logic [63:0]        rx_reg;
    logic [6:0]         bit_cnt_reg;
    logic [TAG_W-1:0]   req_tag_reg;
    logic               buf_valid_reg;
    logic [TAG_W-1:0]   buf_tag_reg;
    logic [63:0]        buf_data_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [23:0]        req_addr24;
    logic [31:0]        read_frame;
    logic               buf_hit;
    logic               gen_en;
    logic               gen_sck_en;
    logic               sck_tick;
    logic               sck_rise;
    logic               sck_fall;
    logic               unused_inputs;

    assign req_tag    = i_req_addr[abits-1:3];
    assign req_addr24 = 24'({req_tag, 3'b000});
    assign read_frame = {SPI_CMD_READ, req_addr24};
    assign buf_hit    = buf_valid_reg && (buf_tag_reg == req_tag);

    assign unused_inputs = ^{i_req_size, i_req_wdata, i_req_wstrb, i_req_last,
                             i_req_addr[2:0],
                             i_req_addr[CFG_SYSBUS_ADDR_BITS-1:abits]};

    // The divider also times the CS# high gap, with SCK held low there
    assign gen_en     = (state_reg == ST_SHIFT) || (state_reg == ST_DESEL);
    assign gen_sck_en = (state_reg == ST_SHIFT);

    spi_sck_gen #(
        .sck_div (sck_div)
    ) u_sck_gen (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_en     (gen_en),
        .i_sck_en (gen_sck_en),
        .o_sck    (o_spi_sck),
        .o_tick   (sck_tick),
        .o_rise   (sck_rise),
        .o_fall   (sck_fall)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            cs_n_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            bit_cnt_reg    <= '0;
            req_tag_reg    <= '0;
            buf_valid_reg  <= 1'b0;
            buf_tag_reg    <= '0;
            buf_data_reg   <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_req_valid && ready_reg) begin
                        ready_reg <= 1'b0;
                        if (i_req_write) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            err_reg        <= 1'b1;
                            rdata_reg      <= '0;
                        end else if (buf_hit) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            err_reg        <= 1'b0;
                            rdata_reg      <= buf_data_reg;
                        end else begin
                            state_reg   <= ST_SHIFT;
                            tx_reg      <= read_frame;
                            mosi_reg    <= read_frame[31];
                            cs_n_reg    <= 1'b0;
                            bit_cnt_reg <= '0;
                            req_tag_reg <= req_tag;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (sck_rise && (bit_cnt_reg >= 7'(SPI_TX_BITS))) begin
                        rx_reg[rx_bit_pos(bit_cnt_reg[5:0])] <= i_spi_miso;
                    end
                    if (sck_fall) begin
                        if (bit_cnt_reg == 7'(SPI_FRAME_SCK - 1)) begin
                            state_reg      <= ST_DESEL;
                            bit_cnt_reg    <= '0;
                            cs_n_reg       <= 1'b1;
                            mosi_reg       <= 1'b0;
                            buf_valid_reg  <= 1'b1;
                            buf_tag_reg    <= req_tag_reg;
                            buf_data_reg   <= rx_reg;
                            resp_valid_reg <= 1'b1;
                            err_reg        <= 1'b0;
                            rdata_reg      <= rx_reg;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 7'd1;
                            // MOSI idles low once the command/address has gone out
                            if (bit_cnt_reg < 7'(SPI_TX_BITS - 1)) begin
                                mosi_reg <= tx_reg[30];
                                tx_reg   <= {tx_reg[30:0], 1'b0};
                            end else begin
                                mosi_reg <= 1'b0;
                            end
                        end
                    end
                end

                ST_DESEL: begin
                    if (sck_tick) begin
                        if (bit_cnt_reg == 7'd1) begin
                            state_reg <= ST_IDLE;
                            ready_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 7'd1;
                        end
                    end
                end

                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    cs_n_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready  = ready_reg;
    assign o_resp_valid = resp_valid_reg;
    assign o_resp_rdata = rdata_reg;
    assign o_resp_err   = err_reg;
    assign o_spi_cs_n   = cs_n_reg;
    assign o_spi_mosi   = mosi_reg;

endmodule
